// File: rtl/serial_tx_ctrl.sv
// -----------------------------------------------------------------------------
// serial_tx_ctrl
//
// Sequences a parallel-in, serial-out shift datapath so that each accepted
// word leaves on a single line as a frame: one start bit (0), WIDTH data
// bits, one stop bit (1), then GAP idle-high bit times. One bit time lasts
// from one shift_en tick to the next. Words are taken in with a valid/ready
// handshake that only completes while the controller is idle.
//
// Parameters:
//   WIDTH     data bits per frame (2..32)
//   MSB_FIRST 0 = LSB leaves first, 1 = MSB leaves first
//   GAP       idle-high bit times after the stop bit (0..15)
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   load_data   word to transmit
//   load_valid  load_data is valid
//   load_ready  controller is idle and will take a word on this edge
//   shift_en    bit-rate tick
//   y           registered serial output, idles high
//   busy        controller is not idle
//   frame       data bits are being sent
//   done        registered one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module serial_tx_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int GAP       = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             y,
    output logic             busy,
    output logic             frame,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    // Unreachable when GAP is 0, so the wrapped value is harmless there.
    localparam logic [3:0] LAST_GAP = 4'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               y_q, y_d;
    logic               done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            y_q       <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            y_q       <= y_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        y_d       = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // Accepting a word does not wait for a bit tick; the start
                // bit then lasts until the next tick.
                if (load_valid) begin
                    shreg_d   = load_data;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (shift_en) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (shift_en) begin
                    if (MSB_FIRST != 0) begin
                        shreg_d = shreg_q << 1;
                    end else begin
                        shreg_d = shreg_q >> 1;
                    end
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (shift_en) begin
                    done_d = 1'b1;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (shift_en) begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                    if (gap_cnt_q == LAST_GAP) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // y is registered, so its next value follows the next state and the
        // next shift register contents.
        if (state_d == ST_START) begin
            y_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            y_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign frame      = (state_q == ST_DATA);
    assign y          = y_q;
    assign done       = done_q;

endmodule
